axi_reg_bank: RTL and testbench
===============================

Name: axi_reg_bank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit axi_reg slave.
- Generalised in register count, data width, per-register read-only/read-write mode and byte strobes.
- Adds per-register access pulses to fabric and a decoupled AW/W capture.
- Sits behind the PS AXI interconnect and exposes control/status words to PL logic.

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- NUM_REGS, 8, number of registers; 1..256.
- ADDR_WIDTH, 12, AXI address width; must satisfy NUM_REGS*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
- RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i read-only (status from reg_in).
- RESET_VAL, 0, value loaded into every RW register on reset.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake
- reg_out  out  NUM_REGS*DATA_WIDTH  current RW register contents, reg i at [i*DW +: DW]
- reg_in  in  NUM_REGS*DATA_WIDTH  status inputs for RO registers
- wr_pulse  out  NUM_REGS  1-cycle pulse when register i is written
- rd_pulse  out  NUM_REGS  1-cycle pulse when register i is read (on AR handshake)

Behaviour:
- Reset, synchronous on ARESET: awready=wready=arready=0 for the reset cycle, then 1. bvalid=rvalid=0, bresp=rresp=0, rdata=0. RW regs=RESET_VAL. Pulses=0. Both FSMs go to IDLE. Reset mid-transaction drops the transaction silently.
- Index = addr[ADDR_WIDTH-1:ADDR_LSB], ADDR_LSB=clog2(DATA_WIDTH/8). Low bits are ignored. Index >= NUM_REGS is out of range.
- Write FSM states:
  - W_IDLE: awready=!aw_held, wready=!w_held. AW and W are captured independently, in either order or the same cycle.
  - W_EXEC, one cycle when both are held: if the target is in range and RW, write each byte where wstrb=1 and pulse wr_pulse[idx]. RO/out-of-range targets are not written and produce no pulse.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
  - Latency: B asserts 2 cycles after the later of the AW/W handshakes. No new AW/W is accepted until the B handshake completes.
- Read FSM states:
  - R_IDLE: arready=1. The AR handshake latches the index and pulses rd_pulse[idx] if in range.
  - R_DATA: asserted the next cycle. rdata = reg (RW) or reg_in slice (RO), sampled at the AR handshake cycle. Out of range returns 0. rvalid and rdata are held stable until rready; arready=0 while in this state.
- Simultaneous read and write of the same register: the read returns the value before the write (read sampled first).
- bresp/rresp = OKAY (2'b00) unless the optional feature is enabled.
- reg_out is driven from flops, with no combinational path from AXI inputs.

Optional Feature:
- Macro AXI_REG_BANK_SLVERR_EN.
- Defined: out-of-range reads and writes, and writes to RO registers, return SLVERR (2'b10); out-of-range read data is 0.
- Undefined: all responses are OKAY and such writes are silently dropped.

Decomposition:
- Package axi_reg_bank_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - wr_state_t {W_IDLE, W_EXEC, W_RESP};
  - rd_state_t {R_IDLE, R_DATA};
  - function addr_lsb(dw).
- One sub-module, axi_reg_bank_strb_reg: a single DATA_WIDTH register with byte-strobe write and reset value. It is generated NUM_REGS times and tied off for RO indices.

Test Plan:
- Default params, write 0x1,0x2,...,0x8 to addr 0x00..0x1C, then read back -> each read matches, bresp/rresp=OKAY, wr_pulse[i] fires once per write.
- Write 0xFFFFFFFF with wstrb=4'b0101 to reg 0 holding 0x00000000 -> reads 0x00FF00FF; reg_out[31:0]=0x00FF00FF.
- W valid 3 cycles before AW, then a separate run with AW and W in the same cycle -> single write, bvalid 2 cycles after the later handshake, bvalid held across 4 cycles of bready=0.
- RO_MASK=8'h02, reg_in slice 1=0xA5A5A5A5, write 0x0 to 0x04 then read 0x04 -> returns 0xA5A5A5A5, no wr_pulse[1]; with AXI_REG_BANK_SLVERR_EN, bresp=SLVERR.
- Read 0x40 (index 16, out of range) -> rdata=0, rresp=OKAY without the macro and SLVERR with it; no rd_pulse.
- Assert ARESET while rvalid=1 with rready=0 -> next cycle rvalid=0, regs back to RESET_VAL, and the next read returns RESET_VAL.

Source files
------------

// File: rtl/axi_reg_bank_pkg.sv
// rtl/axi_reg_bank_pkg.sv - shared response codes, FSM state types and address helper for axi_reg_bank
package axi_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Number of byte-offset address bits below the register index.
    function automatic int addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi_reg_bank_strb_reg.sv
// rtl/axi_reg_bank_strb_reg.sv - single register with byte-strobe write and reset value
module axi_reg_bank_strb_reg
    import axi_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   q
);

    // Only the bytes whose strobe is set are replaced on a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_reg_bank.sv
// rtl/axi_reg_bank.sv - AXI4-Lite register bank top; define AXI_REG_BANK_SLVERR_EN for SLVERR on bad accesses
module axi_reg_bank
    import axi_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;
`ifdef AXI_REG_BANK_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;
    logic                  ready_en;
    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel, rd_sel, reg_we;
    logic                  wr_hit, rd_hit, wr_ok;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  aw_hs, w_hs, b_hs, ar_hs;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[ADDR_LSB-1:0],
                           s_axi_araddr[ADDR_LSB-1:0], reg_in};

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign b_hs   = s_axi_bvalid && s_axi_bready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // Holds the ready outputs low for the cycle following a reset edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = ready_en && !aw_held;
                s_axi_wready  = ready_en && !w_held;
                if (aw_held && w_held) wr_next = W_EXEC;
            end
            W_EXEC: wr_next = W_RESP;
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Decode the held write index; RO and out-of-range targets are not writable.
    always_comb begin
        wr_sel = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == IDX_W'(i)) begin
                wr_sel[i] = 1'b1;
                wr_hit    = 1'b1;
            end
        end
    end

    assign wr_ok  = wr_hit && ((wr_sel & RO_MASK) == '0);
    assign reg_we = (wr_state == W_EXEC && wr_ok) ? wr_sel : '0;

    // Write channel state, independent AW/W capture, response code and write pulses.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state    <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            s_axi_bresp <= RESP_OKAY;
            wr_pulse    <= '0;
        end else begin
            wr_state <= wr_next;
            wr_pulse <= reg_we;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (wr_state == W_EXEC) begin
                s_axi_bresp <= (SLVERR_EN && !wr_ok) ? RESP_SLVERR : RESP_OKAY;
            end
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = ready_en;
                if (ar_hs) rd_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read mux straight off the AR address: RW registers or the RO status slice.
    always_comb begin
        rd_sel = '0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_sel[i] = 1'b1;
                rd_hit    = 1'b1;
                rd_val    = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : reg_q[i];
            end
        end
    end

    // Read data is captured at the AR handshake, before any same-edge register write lands.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state    <= R_IDLE;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
            rd_pulse    <= '0;
        end else begin
            rd_state <= rd_next;
            rd_pulse <= ar_hs ? rd_sel : '0;
            if (ar_hs) begin
                s_axi_rdata <= rd_hit ? rd_val : '0;
                s_axi_rresp <= (SLVERR_EN && !rd_hit) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            axi_reg_bank_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
                .clk   (ACLK),
                .rst   (ARESET),
                .we    (1'b0),
                .wdata (w_data),
                .wstrb (w_strb),
                .q     (reg_q[i])
            );
        end else begin : g_rw
            axi_reg_bank_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
                .clk   (ACLK),
                .rst   (ARESET),
                .we    (reg_we[i]),
                .wdata (w_data),
                .wstrb (w_strb),
                .q     (reg_q[i])
            );
        end
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
    end

endmodule

// File: tb/tb_axi_reg_bank.sv
// tb/tb_axi_reg_bank.sv - self-checking bench for axi_reg_bank with a behavioural register model
`timescale 1ns/1ps
module tb_axi_reg_bank;

    localparam int             DW = 32;
    localparam int             NR = 8;
    localparam int             AW = 12;
    localparam int             SW = DW / 8;
    localparam logic [NR-1:0]  RO = 8'h02;
    localparam logic [DW-1:0]  RV = 32'h0;
`ifdef AXI_REG_BANK_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     awaddr = '0, araddr = '0;
    logic [2:0]        awprot = 3'd0, arprot = 3'd0;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0]     wdata = '0;
    logic [SW-1:0]     wstrb = '0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [DW-1:0]     rdata;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  reg_in = '0;
    logic [NR-1:0]     wr_pulse, rd_pulse;

    logic [DW-1:0]     model [NR];
    int                checks = 0;
    int                failures = 0;

    axi_reg_bank #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO), .RESET_VAL(RV)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_read(input int idx);
        if (idx >= NR) return '0;
        if (RO[idx]) return reg_in[idx*DW +: DW];
        return model[idx];
    endfunction

    function automatic logic [1:0] exp_resp(input int idx, input bit is_wr);
        bit err;
        err = (idx >= NR) || (is_wr && RO[idx]);
        return (err && SLV) ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (idx < NR && !RO[idx])
            for (int b = 0; b < SW; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [NR*DW-1:0] model_out();
        logic [NR*DW-1:0] v = '0;
        for (int i = 0; i < NR; i++)
            if (!RO[i]) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    function automatic logic [NR*DW-1:0] rw_mask();
        logic [NR*DW-1:0] v = '0;
        for (int i = 0; i < NR; i++)
            if (!RO[i]) v[i*DW +: DW] = '1;
        return v;
    endfunction

    task automatic axi_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input int aw_dly, input int w_dly, input int b_hold);
        int cyc, aw_e, w_e, b_e, n_pulse, later;
        bit hs_aw, hs_w, stable, writable;
        logic [NR-1:0] seen, exp_sel;
        writable = (idx < NR) && !RO[idx];
        exp_sel  = writable ? (NR'(1) << idx) : '0;
        cyc = 0; aw_e = -1; w_e = -1; b_e = -1; n_pulse = 0; seen = '0;
        awaddr = AW'(idx * SW); wdata = d; wstrb = s;
        while ((aw_e < 0 || w_e < 0) && cyc < 40) begin
            awvalid = (aw_e < 0) && (cyc >= aw_dly);
            wvalid  = (w_e < 0) && (cyc >= w_dly);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step(); cyc++;
            if (hs_aw) aw_e = cyc;
            if (hs_w)  w_e  = cyc;
            seen |= wr_pulse; n_pulse += $countones(wr_pulse);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_handshake", {aw_e >= 0, w_e >= 0}, 2'b11);
        later = (aw_e > w_e) ? aw_e : w_e;
        while (b_e < 0 && cyc < 80) begin
            if (bvalid) b_e = cyc;
            else begin
                step(); cyc++;
                seen |= wr_pulse; n_pulse += $countones(wr_pulse);
            end
        end
        check("b_latency", b_e - later, 2);
        stable = 1'b1;
        for (int k = 0; k < b_hold; k++) begin
            step();
            seen |= wr_pulse; n_pulse += $countones(wr_pulse);
            if (!bvalid) stable = 1'b0;
        end
        check("bvalid_hold", stable, 1'b1);
        check("bresp", bresp, exp_resp(idx, 1'b1));
        bready = 1'b1;
        step();
        bready = 1'b0;
        seen |= wr_pulse; n_pulse += $countones(wr_pulse);
        check("bvalid_drop", bvalid, 1'b0);
        check("wr_pulse", {seen, 8'(n_pulse)}, {exp_sel, 8'(writable ? 1 : 0)});
        model_write(idx, d, s);
    endtask

    task automatic axi_read(input int idx, input int r_hold);
        logic [DW-1:0] expv;
        logic [NR-1:0] exp_sel;
        int cyc;
        bit done, stable;
        expv    = exp_read(idx);
        exp_sel = (idx < NR) ? (NR'(1) << idx) : '0;
        araddr = AW'(idx * SW); arvalid = 1'b1; done = 1'b0; cyc = 0;
        while (!done && cyc < 20) begin
            done = arready;
            step(); cyc++;
        end
        arvalid = 1'b0;
        check("ar_handshake", done, 1'b1);
        check("rd_pulse", rd_pulse, exp_sel);
        check("rvalid_rise", rvalid, 1'b1);
        reg_in = ~reg_in;
        stable = 1'b1;
        for (int k = 0; k < r_hold; k++) begin
            step();
            if (!rvalid || rdata !== expv || rd_pulse !== '0) stable = 1'b0;
        end
        check("r_hold_stable", stable, 1'b1);
        check("rdata", rdata, expv);
        check("rresp", rresp, exp_resp(idx, 1'b0));
        rready = 1'b1;
        step();
        rready = 1'b0;
        reg_in = ~reg_in;
        check("rvalid_drop", rvalid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] old_v, new_v, d;
        int idx;

        for (int i = 0; i < NR; i++) begin
            reg_in[i*DW +: DW] = $urandom;
            model[i] = RV;
        end
        reg_in[1*DW +: DW] = 32'hA5A5A5A5;

        // Reset state
        step(); step();
        check("reset_ready", {awready, wready, arready}, 3'b000);
        check("reset_valid", {bvalid, rvalid}, 2'b00);
        check("reset_rdata", rdata, '0);
        check("reset_resp", {bresp, rresp}, 4'b0000);
        check("reset_pulses", {wr_pulse, rd_pulse}, '0);
        check("reset_reg_out", reg_out & rw_mask(), model_out());
        rst = 1'b0;
        step();
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        // Byte strobes on a cleared register
        axi_write(0, 32'hFFFFFFFF, 4'b0101, 0, 0, 0);
        check("strb_reg_out", reg_out[31:0], 32'h00FF00FF);
        axi_read(0, 0);

        // Sequential fill and readback, including the RO status register
        for (int i = 0; i < NR; i++) axi_write(i, DW'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < NR; i++) axi_read(i, 0);
        check("fill_reg_out", reg_out & rw_mask(), model_out());

        // W leads AW by three cycles, then same-cycle AW/W, both with B back-pressure
        axi_write(2, $urandom, 4'hF, 3, 0, 4);
        axi_write(4, $urandom, 4'hF, 0, 0, 4);
        axi_write(5, $urandom, 4'hF, 0, 2, 1);
        axi_read(2, 0);
        axi_read(4, 1);
        axi_read(5, 0);

        // Out of range accesses
        axi_read(16, 2);
        axi_write(16, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("oor_reg_out", reg_out & rw_mask(), model_out());

        // Read and write of the same register on the same edge returns the old value
        old_v = model[3];
        new_v = ~old_v;
        awaddr = AW'(3 * SW); araddr = AW'(3 * SW); wdata = new_v; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("rw_same_edge_rvalid", rvalid, 1'b1);
        check("rw_same_edge_rdata", rdata, old_v);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rw_same_edge_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        model_write(3, new_v, 4'hF);
        axi_read(3, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, NR + 1);
            d   = $urandom;
            reg_in[1*DW +: DW] = $urandom;
            axi_write(idx, d, SW'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2));
            check("rand_reg_out", reg_out & rw_mask(), model_out());
            axi_read($urandom_range(0, NR + 1), $urandom_range(0, 2));
        end

        // Reset while a read response is stalled
        araddr = AW'(6 * SW); arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("pre_reset_rvalid", rvalid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = RV;
        check("mid_reset_rvalid", rvalid, 1'b0);
        check("mid_reset_arready", arready, 1'b0);
        check("mid_reset_reg_out", reg_out & rw_mask(), model_out());
        step();
        check("post_reset_arready", arready, 1'b1);
        axi_read(6, 0);
        axi_read(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
